// File: rtl/or1200_vlx_packer.sv
// VLX bit packer: accumulates variable-length codes, emits bytes MSB-first.
// Optional 0xFF byte stuffing, SPR flush with 1-padding, deferred base write.
module or1200_vlx_packer #(
  parameter int ACC_W    = 32,
  parameter int MAX_BITS = 16,
  parameter int NB_W     = 5,
  parameter int STUFF_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            set_bit_op_i,
  input  logic [NB_W-1:0] num_bits_to_write_i,
  input  logic [31:0]     dat_i,
  input  logic            ack_i,
  input  logic            spr_cs,
  input  logic            spr_write,
  input  logic [1:0]      spr_addr,
  input  logic [31:0]     spr_dat_i,
  output logic [31:0]     spr_dat_o,
  output logic            stall_cpu_o,
  output logic            store_byte_o,
  output logic [31:0]     vlx_addr_o,
  output logic [31:0]     dat_o
);

  localparam int FW  = $clog2(ACC_W + 1);
  localparam int SW  = $clog2(ACC_W + MAX_BITS + 8) + 1;
  localparam int AW1 = ACC_W + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             store_q, store_d;
  logic             stuff_q, stuff_d;
  logic             flush_q, flush_d;
  logic             apend_q, apend_d;
  logic [7:0]       byte_q, byte_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      aval_q, aval_d;

  logic [SW-1:0]    fill_sum;
  logic             room, busy, accept;
  logic             emit, stuff_go, pad;
  logic             wr_base, wr_flush, fill_ge8;
  logic [NB_W-1:0]  sh;
  logic [ACC_W-1:0] ins;
  logic [2:0]       pad_n;
  logic [7:0]       emit_byte;

  always_comb begin
    fill_ge8  = fill_q >= FW'(8);
    busy      = store_q | stuff_q | flush_q | fill_ge8;
    fill_sum  = SW'(fill_q) + SW'(num_bits_to_write_i);
    room      = fill_sum <= SW'(ACC_W);
    accept    = set_bit_op_i & room & ~flush_q;
    pad_n     = 3'd0 - fill_q[2:0];
    pad       = flush_q & (pad_n != 3'd0);
    emit      = ~store_q & ~stuff_q & fill_ge8;
    stuff_go  = ~store_q & stuff_q;
    wr_base   = spr_cs & spr_write & spr_addr[1];
    wr_flush  = spr_cs & spr_write & (spr_addr == 2'b01)
              & spr_dat_i[0];
    emit_byte = 8'(acc_q >> (fill_q - FW'(8)));

    // Code insert and flush padding share one shifter
    sh = '0;
    if (accept) sh = num_bits_to_write_i;
    else if (pad) sh = NB_W'(pad_n);
    ins = ACC_W'((AW1'(1) << sh) - AW1'(1));
    if (accept) ins = ins & ACC_W'(dat_i);

    acc_d  = (acc_q << sh) | ins;
    fill_d = fill_q + FW'(sh) - (emit ? FW'(8) : FW'(0));

    store_d = store_q;
    byte_d  = byte_q;
    stuff_d = stuff_q;
    addr_d  = addr_q;
    aval_d  = aval_q;
    apend_d = apend_q;
    flush_d = flush_q;

    if (store_q & ack_i) begin
      store_d = 1'b0;
      addr_d  = addr_q + 32'd1;
    end
    if (stuff_go) begin
      store_d = 1'b1;
      byte_d  = 8'h00;
      stuff_d = 1'b0;
    end else if (emit) begin
      store_d = 1'b1;
      byte_d  = emit_byte;
      if (STUFF_EN != 0 && emit_byte == 8'hFF)
        stuff_d = 1'b1;
    end

    if (flush_q & (fill_q == '0) & ~store_q & ~stuff_q)
      flush_d = 1'b0;
    if (wr_flush) flush_d = 1'b1;

    if (apend_q & ~busy) begin
      addr_d  = aval_q;
      apend_d = 1'b0;
    end
    if (wr_base) begin
      if (~busy) begin
        addr_d  = spr_dat_i;
        apend_d = 1'b0;
      end else begin
        aval_d  = spr_dat_i;
        apend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      fill_q  <= '0;
      store_q <= 1'b0;
      stuff_q <= 1'b0;
      flush_q <= 1'b0;
      apend_q <= 1'b0;
      byte_q  <= '0;
      addr_q  <= '0;
      aval_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      store_q <= store_d;
      stuff_q <= stuff_d;
      flush_q <= flush_d;
      apend_q <= apend_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      aval_q  <= aval_d;
    end
  end

  assign stall_cpu_o  = (set_bit_op_i & ~(room & ~flush_q))
                      | flush_q | apend_q | (wr_base & busy);
  assign spr_dat_o    = spr_addr[1] ? addr_q
                      : {24'h0, busy, 7'(fill_q)};
  assign store_byte_o = store_q;
  assign vlx_addr_o   = addr_q;
  assign dat_o        = {24'h0, byte_q};

endmodule

// File: tb/tb_or1200_vlx_packer.sv
// Bench for or1200_vlx_packer: bit-stream reference model,
// directed scenarios plus randomized ops and ack delays.
module tb_or1200_vlx_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        op0, ack0, cs, wr;
  logic [4:0]  n0;
  logic [31:0] d0, sd;
  logic [1:0]  sa;
  logic [31:0] sdo0, addr0, do0;
  logic        stall0, st0;

  logic        op1, ack1;
  logic [4:0]  n1;
  logic [31:0] d1;
  logic [31:0] sdo1, addr1, do1;
  logic        stall1, st1;

  or1200_vlx_packer u0 (
    .clk_i(clk), .rst_i(rst),
    .set_bit_op_i(op0), .num_bits_to_write_i(n0),
    .dat_i(d0), .ack_i(ack0),
    .spr_cs(cs), .spr_write(wr),
    .spr_addr(sa), .spr_dat_i(sd),
    .spr_dat_o(sdo0), .stall_cpu_o(stall0),
    .store_byte_o(st0), .vlx_addr_o(addr0),
    .dat_o(do0)
  );

  or1200_vlx_packer #(.STUFF_EN(0)) u1 (
    .clk_i(clk), .rst_i(rst),
    .set_bit_op_i(op1), .num_bits_to_write_i(n1),
    .dat_i(d1), .ack_i(ack1),
    .spr_cs(1'b0), .spr_write(1'b0),
    .spr_addr(2'b00), .spr_dat_i(32'h0),
    .spr_dat_o(sdo1), .stall_cpu_o(stall1),
    .store_byte_o(st1), .vlx_addr_o(addr1),
    .dat_o(do1)
  );

  int checks = 0;
  int fails = 0;
  int stall_cnt = 0;
  bit ack_on, ack_rand, last_acc0, last_acc1;
  bit bits0[$];
  bit bits1[$];
  logic [7:0]  exq0[$];
  logic [7:0]  exq1[$];
  logic [7:0]  seen0[$];
  logic [7:0]  seen1[$];
  logic [31:0] seena0[$];
  logic [31:0] seena1[$];
  logic [31:0] exa0, exa1, old_a, rv;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic void form0();
    logic [7:0] b;
    while (bits0.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits0.pop_front()};
      exq0.push_back(b);
      if (b == 8'hFF) exq0.push_back(8'h00);
    end
  endfunction

  function automatic void form1();
    logic [7:0] b;
    while (bits1.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits1.pop_front()};
      exq1.push_back(b);
    end
  endfunction

  function automatic void push0(input int n, input logic [31:0] d);
    for (int i = n - 1; i >= 0; i--) bits0.push_back(d[i]);
    form0();
  endfunction

  function automatic void push1(input int n, input logic [31:0] d);
    for (int i = n - 1; i >= 0; i--) bits1.push_back(d[i]);
    form1();
  endfunction

  function automatic void pad0();
    while (bits0.size() % 8 != 0) bits0.push_back(1'b1);
    form0();
  endfunction

  task automatic hs0();
    logic [7:0] e;
    seen0.push_back(do0[7:0]);
    seena0.push_back(addr0);
    checks++;
    assert (exq0.size() > 0) else begin
      fails++;
      $error("FAIL store0_extra obs=%h exp=none", do0);
    end
    if (exq0.size() > 0) begin
      e = exq0.pop_front();
      chk("store0_byte", do0, {24'h0, e});
      chk("store0_addr", addr0, exa0);
    end
    exa0 = exa0 + 32'd1;
  endtask

  task automatic hs1();
    logic [7:0] e;
    seen1.push_back(do1[7:0]);
    seena1.push_back(addr1);
    checks++;
    assert (exq1.size() > 0) else begin
      fails++;
      $error("FAIL store1_extra obs=%h exp=none", do1);
    end
    if (exq1.size() > 0) begin
      e = exq1.pop_front();
      chk("store1_byte", do1, {24'h0, e});
      chk("store1_addr", addr1, exa1);
    end
    exa1 = exa1 + 32'd1;
  endtask

  // Called one unit after a rising edge; samples mid-cycle
  task automatic step();
    #1;
    last_acc0 = op0 && !stall0;
    last_acc1 = op1 && !stall1;
    if (op0 && stall0) stall_cnt++;
    if (last_acc0) push0(int'(n0), d0);
    if (last_acc1) push1(int'(n1), d1);
    if (cs && wr && sa == 2'b01 && sd[0]) pad0();
    ack0 = st0 && ack_on && (!ack_rand || $urandom_range(1, 0) == 1);
    ack1 = st1;
    if (st0 && ack0) hs0();
    if (st1 && ack1) hs1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op0(input int n, input logic [31:0] d);
    op0 = 1'b1; n0 = 5'(n); d0 = d;
    for (int k = 0; k < 300; k++) begin
      step();
      if (last_acc0) break;
    end
    op0 = 1'b0;
    checks++;
    assert (last_acc0) else begin
      fails++;
      $error("FAIL op0_timeout obs=stalled exp=accepted");
    end
  endtask

  task automatic do_op1(input int n, input logic [31:0] d);
    op1 = 1'b1; n1 = 5'(n); d1 = d;
    for (int k = 0; k < 300; k++) begin
      step();
      if (last_acc1) break;
    end
    op1 = 1'b0;
    checks++;
    assert (last_acc1) else begin
      fails++;
      $error("FAIL op1_timeout obs=stalled exp=accepted");
    end
  endtask

  task automatic spr_wr(input logic [1:0] a, input logic [31:0] v);
    cs = 1'b1; wr = 1'b1; sa = a; sd = v;
    step();
    cs = 1'b0; wr = 1'b0; sa = 2'b00; sd = '0;
  endtask

  task automatic drain0(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      if (!st0 && !stall0 && !sdo0[7] && exq0.size() == 0) break;
      step();
    end
    checks++;
    assert (k < 400) else begin
      fails++;
      $error("FAIL %s_timeout obs=%0d exp=<400", tag, k);
    end
    chk({tag, "_status"}, sdo0, {24'h0, 1'b0, 7'(bits0.size())});
  endtask

  task automatic drain1(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      if (!st1 && !stall1 && !sdo1[7] && exq1.size() == 0) break;
      step();
    end
    checks++;
    assert (k < 400) else begin
      fails++;
      $error("FAIL %s_timeout obs=%0d exp=<400", tag, k);
    end
    chk({tag, "_status"}, sdo1, {24'h0, 1'b0, 7'(bits1.size())});
  endtask

  function automatic void clr_model();
    bits0.delete(); bits1.delete();
    exq0.delete(); exq1.delete();
    seen0.delete(); seen1.delete();
    seena0.delete(); seena1.delete();
    exa0 = '0; exa1 = '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
    clr_model();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    op0 = 0; ack0 = 0; cs = 0; wr = 0; n0 = 0; d0 = 0; sd = 0; sa = 0;
    op1 = 0; ack1 = 0; n1 = 0; d1 = 0;
    ack_on = 1'b1; ack_rand = 1'b0;
    clr_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_store", 32'(st0), 0);
    chk("rst_stall", 32'(stall0), 0);
    chk("rst_addr", addr0, 0);
    chk("rst_dat", do0, 0);
    chk("rst_status", sdo0, 0);
    sa = 2'b10;
    #1;
    chk("rst_spr_addr", sdo0, 0);
    sa = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic packing at a programmed base
    spr_wr(2'b10, 32'h1000);
    exa0 = 32'h1000;
    chk("t1_base", addr0, 32'h1000);
    stall_cnt = 0;
    do_op0(8, 32'hA5);
    do_op0(4, 32'h3);
    do_op0(4, 32'hC);
    chk("t1_nostall", stall_cnt, 0);
    drain0("t1");
    chk("t1_b0", {24'h0, seen0[0]}, 32'hA5);
    chk("t1_b1", {24'h0, seen0[1]}, 32'h3C);
    chk("t1_a1", seena0[1], 32'h1001);
    chk("t1_final_addr", addr0, 32'h1002);

    // Stuffing on and off
    do_reset();
    do_op0(8, 32'hFF);
    do_op0(8, 32'h12);
    drain0("t2s");
    chk("t2s_cnt", seen0.size(), 3);
    chk("t2s_b1", {24'h0, seen0[1]}, 32'h00);
    chk("t2s_b2", {24'h0, seen0[2]}, 32'h12);
    chk("t2s_a2", seena0[2], 32'h2);
    do_op1(8, 32'hFF);
    do_op1(8, 32'h12);
    drain1("t2n");
    chk("t2n_cnt", seen1.size(), 2);
    chk("t2n_b1", {24'h0, seen1[1]}, 32'h12);
    chk("t2n_a1", seena1[1], 32'h1);

    // Accumulator full while ack withheld
    ack_on = 1'b0;
    stall_cnt = 0;
    do_op0(16, $urandom);
    do_op0(16, $urandom);
    chk("t3_first_nostall", stall_cnt, 0);
    op0 = 1'b1; n0 = 5'd16; d0 = $urandom;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_acc_held", 32'(last_acc0), 0);
      chk("t3_stall", 32'(stall0), 1);
    end
    ack_on = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (last_acc0) break;
    end
    op0 = 1'b0;
    chk("t3_accepted", 32'(last_acc0), 1);
    drain0("t3");

    // Flush pads with ones
    seen0.delete();
    do_op0(3, 32'h5);
    spr_wr(2'b01, 32'h1);
    chk("t4_stall", 32'(stall0), 1);
    for (int k = 0; k < 50; k++) begin
      if (!stall0) break;
      step();
    end
    chk("t4_unstall", 32'(stall0), 0);
    chk("t4_cnt", seen0.size(), 1);
    chk("t4_byte", {24'h0, seen0[0]}, 32'hBF);
    chk("t4_status", sdo0, 0);

    // Base write while a store is pending
    seena0.delete();
    ack_on = 1'b0;
    do_op0(8, $urandom);
    for (int k = 0; k < 10; k++) begin
      if (st0) break;
      step();
    end
    old_a = exa0;
    chk("t5_pending", 32'(st0), 1);
    cs = 1'b1; wr = 1'b1; sa = 2'b10; sd = 32'h2000_0000;
    #1;
    chk("t5_wr_stall", 32'(stall0), 1);
    step();
    cs = 1'b0; wr = 1'b0; sa = 2'b00; sd = '0;
    repeat (2) step();
    chk("t5_pend_stall", 32'(stall0), 1);
    chk("t5_old_addr", addr0, old_a);
    ack_on = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!stall0) break;
      step();
    end
    chk("t5_unstall", 32'(stall0), 0);
    chk("t5_new_addr", addr0, 32'h2000_0000);
    chk("t5_a_old", seena0[0], old_a);
    exa0 = 32'h2000_0000;
    do_op0(8, $urandom);
    drain0("t5");
    chk("t5_a_new", seena0[1], 32'h2000_0000);

    // Randomized ops, flushes and ack delays
    ack_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      rv = $urandom;
      if (rv[3:0] == 4'd0) spr_wr(2'b01, 32'h1);
      else do_op0(int'($urandom_range(16, 0)), $urandom);
    end
    spr_wr(2'b01, 32'h1);
    drain0("t6");
    chk("t6_addr", addr0, exa0);
    ack_rand = 1'b0;

    // Asynchronous reset mid-store
    ack_on = 1'b0;
    do_op0(16, $urandom);
    do_op0(4, $urandom);
    chk("t7_store", 32'(st0), 1);
    chk("t7_status", sdo0, 32'h8C);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_store", 32'(st0), 0);
    chk("t7_rst_stall", 32'(stall0), 0);
    chk("t7_rst_addr", addr0, 0);
    chk("t7_rst_dat", do0, 0);
    chk("t7_rst_status", sdo0, 0);
    clr_model();
    #1;
    rst = 1'b0;
    ack0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    ack0 = 1'b0;
    chk("t7_ack_ignored", addr0, 0);
    ack_on = 1'b1;
    do_op0(8, 32'h55);
    drain0("t7");
    chk("t7_b0", {24'h0, seen0[0]}, 32'h55);
    chk("t7_a0", seena0[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
